// File: rtl/qnigma_tcp_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : qnigma_pkg
// Description : Shared TCP transmit types: connection block, header
//               descriptor, TCP flag bit constants, transmit source select
//               and default delayed-ACK tuning values.
// Revision    : 1.0  initial release
// ============================================================================
package qnigma_pkg;

    // Delayed-ACK defaults
    localparam int ACK_DELAY_TICKS = 4;
    localparam int ACK_COALESCE    = 2;
    localparam int TCP_MSS         = 1460;

    typedef enum logic [2:0] {
        tcp_closed      = 3'd0,
        tcp_listen      = 3'd1,
        tcp_syn_sent    = 3'd2,
        tcp_syn_rcvd    = 3'd3,
        tcp_established = 3'd4,
        tcp_fin_wait    = 3'd5,
        tcp_close_wait  = 3'd6,
        tcp_last_ack    = 3'd7
    } tcp_stat_t;

    typedef struct packed {
        tcp_stat_t   status;
        logic [31:0] loc_seq;
        logic [31:0] loc_ack;
        logic [15:0] loc_wnd;
    } tcb_t;

    typedef logic [7:0] tcp_flags_t;

    localparam tcp_flags_t c_TCP_FIN = 8'h01;
    localparam tcp_flags_t c_TCP_SYN = 8'h02;
    localparam tcp_flags_t c_TCP_RST = 8'h04;
    localparam tcp_flags_t c_TCP_PSH = 8'h08;
    localparam tcp_flags_t c_TCP_ACK = 8'h10;

    typedef struct packed {
        tcp_flags_t  flags;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] wnd;
        logic [15:0] len;
    } tcp_tx_meta_t;

    // Frame source chosen by the arbiter
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_RST  = 3'd1,
        SEL_FIN  = 3'd2,
        SEL_DAT  = 3'd3,
        SEL_ACK  = 3'd4,
        SEL_KA   = 3'd5
    } tx_sel_t;

endpackage
`default_nettype wire

// File: rtl/qnigma_tcp_ack_dly.sv
`default_nettype none
// ============================================================================
// Module      : qnigma_tcp_ack_dly
// Description : Delayed-ACK bookkeeping. Counts received in-order segments
//               and elapsed ms ticks while an ACK is owed; flags the pure
//               ACK as due on segment coalesce count or delay expiry.
// Ports       : clk, rst       clock / sync active-high reset
//               i_flush        connection closed: drop everything
//               i_ack_req      segment with payload received
//               i_tick         1 ms strobe
//               i_clr          a frame carrying ACK has completed
//               o_due          pure ACK must be sent now
// Revision    : 1.0  initial release
// ============================================================================
module qnigma_tcp_ack_dly
    import qnigma_pkg::*;
#(
    parameter int ACK_DELAY_TICKS = qnigma_pkg::ACK_DELAY_TICKS,
    parameter int ACK_COALESCE    = qnigma_pkg::ACK_COALESCE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_ack_req,
    input  logic i_tick,
    input  logic i_clr,
    output logic o_due
);

    localparam int c_SEG_W = (ACK_COALESCE    < 1) ? 1 : $clog2(ACK_COALESCE + 1);
    localparam int c_DLY_W = (ACK_DELAY_TICKS < 1) ? 1 : $clog2(ACK_DELAY_TICKS + 1);
    localparam logic [c_SEG_W-1:0] c_SEG_MAX = c_SEG_W'(ACK_COALESCE);
    localparam logic [c_DLY_W-1:0] c_DLY_MAX = c_DLY_W'(ACK_DELAY_TICKS);

    logic               r_pend;
    logic [c_SEG_W-1:0] r_seg_cnt;
    logic [c_DLY_W-1:0] r_dly_cnt;
    logic               w_seg_sat;
    logic               w_dly_sat;

    assign w_seg_sat = (r_seg_cnt >= c_SEG_MAX);
    assign w_dly_sat = (r_dly_cnt == c_DLY_MAX);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_pend    <= 1'b0;
            r_seg_cnt <= '0;
            r_dly_cnt <= '0;
        end else if (i_ack_req) begin
            r_pend <= 1'b1;
            // A request coinciding with the clearing frame starts a fresh count
            if (i_clr || !r_pend) begin
                r_seg_cnt <= c_SEG_W'(1);
                r_dly_cnt <= '0;
            end else begin
                if (!w_seg_sat)
                    r_seg_cnt <= r_seg_cnt + c_SEG_W'(1);
                if (i_tick && !w_dly_sat)
                    r_dly_cnt <= r_dly_cnt + c_DLY_W'(1);
            end
        end else if (i_clr) begin
            r_pend    <= 1'b0;
            r_seg_cnt <= '0;
            r_dly_cnt <= '0;
        end else if (r_pend && i_tick && !w_dly_sat) begin
            r_dly_cnt <= r_dly_cnt + c_DLY_W'(1);
        end
    end

    assign o_due = r_pend && (w_seg_sat || w_dly_sat);

endmodule
`default_nettype wire

// File: rtl/qnigma_tcp_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : qnigma_tcp_tx_arb
// Description : TCP transmit event arbiter for the single active connection.
//               Collects RST, FIN, data, delayed-ACK and keep-alive requests
//               and issues one header descriptor at a time (one in flight).
// Ports       : clk, rst               clock / sync active-high reset
//               i_tick_ms              1 ms strobe
//               i_tcb                  connection block
//               i_ka_send / o_ka_sent  keep-alive request level / done pulse
//               i_ack_req              in-order payload segment received
//               i_dat_req, i_dat_len   data pending level and length
//               o_dat_ack              data descriptor accepted pulse
//               i_fin_req, i_rst_req   close / abort request pulses
//               o_meta_val, i_meta_rdy, o_meta   descriptor handshake
//               i_tx_done              accepted frame fully serialised
// Revision    : 1.0  initial release
// ============================================================================
module qnigma_tcp_tx_arb
    import qnigma_pkg::*;
#(
    parameter int ACK_DELAY_TICKS = qnigma_pkg::ACK_DELAY_TICKS,
    parameter int ACK_COALESCE    = qnigma_pkg::ACK_COALESCE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_tick_ms,
    input  tcb_t         i_tcb,
    input  logic         i_ka_send,
    output logic         o_ka_sent,
    input  logic         i_ack_req,
    input  logic         i_dat_req,
    input  logic [15:0]  i_dat_len,
    output logic         o_dat_ack,
    input  logic         i_fin_req,
    input  logic         i_rst_req,
    output logic         o_meta_val,
    input  logic         i_meta_rdy,
    output tcp_tx_meta_t o_meta,
    input  logic         i_tx_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_SEND = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t       r_state, w_state_nxt;
    tx_sel_t      r_sel, w_sel;
    tcp_tx_meta_t r_meta, w_meta;

    logic r_rst_p;      // RST pending
    logic r_fin_p;      // FIN pending
    logic r_fin_done;   // FIN already sent on this connection
    logic r_lock;       // RST sent: everything muted until the connection closes
    logic r_ka_done;    // keep-alive completed, waiting for ka_send to drop
    logic r_ka_sent;

    logic w_closed, w_done, w_rst_done;
    logic w_rst_new, w_fin_new, w_ack_new;
    logic w_rst_el, w_fin_el, w_dat_el, w_ack_el, w_ka_el, w_ack_due;
    logic w_wake;

    assign w_closed   = (i_tcb.status == tcp_closed);
    assign w_done     = (r_state == S_WAIT) && i_tx_done;
    assign w_rst_done = w_done && (r_sel == SEL_RST);

    assign w_rst_new  = i_rst_req && !r_lock && !w_closed;
    assign w_fin_new  = i_fin_req && !r_lock && !r_fin_done && !w_closed;
    assign w_ack_new  = i_ack_req && !r_lock && !w_closed && !w_rst_done;

    assign w_rst_el   = r_rst_p && !w_closed;
    assign w_fin_el   = r_fin_p && !w_closed;
    assign w_dat_el   = i_dat_req && !r_lock && !w_closed;
    assign w_ack_el   = w_ack_due && !r_lock && !w_closed;
    assign w_ka_el    = i_ka_send && !r_ka_done && !r_lock && !w_closed;

    // Raw request pulses also wake the FSM so a request reaches meta_val in
    // two cycles; ARB then works from the latched flags.
    assign w_wake = w_rst_el | w_rst_new | w_fin_el | w_fin_new |
                    w_dat_el | w_ack_el  | w_ka_el;

    // Every frame carries ACK except RST, and RST completion clears all
    // pending state anyway, so any completion clears the delayed ACK.
    qnigma_tcp_ack_dly #(
        .ACK_DELAY_TICKS (ACK_DELAY_TICKS),
        .ACK_COALESCE    (ACK_COALESCE)
    ) u_ack_dly (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (w_closed),
        .i_ack_req (w_ack_new),
        .i_tick    (i_tick_ms),
        .i_clr     (w_done),
        .o_due     (w_ack_due)
    );

    // Source selection: RST > FIN > DATA > pure ACK > keep-alive
    always_comb begin
        w_sel = SEL_NONE;
        if (w_rst_el)      w_sel = SEL_RST;
        else if (w_fin_el) w_sel = SEL_FIN;
        else if (w_dat_el) w_sel = SEL_DAT;
        else if (w_ack_el) w_sel = SEL_ACK;
        else if (w_ka_el)  w_sel = SEL_KA;
    end

    always_comb begin
        w_meta     = '0;
        w_meta.seq = i_tcb.loc_seq;
        w_meta.ack = i_tcb.loc_ack;
        w_meta.wnd = i_tcb.loc_wnd;
        case (w_sel)
            SEL_RST: begin
                w_meta.flags = c_TCP_RST;
                w_meta.ack   = '0;
            end
            SEL_FIN: w_meta.flags = c_TCP_FIN | c_TCP_ACK;
            SEL_DAT: begin
                w_meta.flags = c_TCP_PSH | c_TCP_ACK;
                w_meta.len   = i_dat_len;
            end
            SEL_ACK: w_meta.flags = c_TCP_ACK;
            SEL_KA: begin
                // Keep-alive probe re-uses the last acknowledged sequence number
                w_meta.flags = c_TCP_ACK;
                w_meta.seq   = i_tcb.loc_seq - 32'd1;
            end
            default: w_meta = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state and outputs
    always_comb begin
        w_state_nxt = r_state;
        o_meta_val  = 1'b0;
        o_dat_ack   = 1'b0;
        case (r_state)
            S_IDLE: if (w_wake) w_state_nxt = S_ARB;
            S_ARB:  w_state_nxt = (w_sel == SEL_NONE) ? S_IDLE : S_SEND;
            S_SEND: begin
                o_meta_val = 1'b1;
                o_dat_ack  = i_meta_rdy && (r_sel == SEL_DAT);
                // An accepted descriptor always finishes; an unaccepted one
                // is withdrawn when the connection closes.
                if (i_meta_rdy)
                    w_state_nxt = S_WAIT;
                else if (w_closed)
                    w_state_nxt = S_IDLE;
            end
            S_WAIT: if (i_tx_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Selection and descriptor are frozen in ARB and held through SEND/WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel  <= SEL_NONE;
            r_meta <= '0;
        end else if (r_state == S_ARB) begin
            r_sel  <= w_sel;
            r_meta <= w_meta;
        end
    end

    // Pending flags
    always_ff @(posedge clk) begin
        if (rst || w_closed) begin
            r_rst_p    <= 1'b0;
            r_fin_p    <= 1'b0;
            r_fin_done <= 1'b0;
            r_lock     <= 1'b0;
        end else if (w_rst_done) begin
            r_rst_p <= 1'b0;
            r_fin_p <= 1'b0;
            r_lock  <= 1'b1;
        end else begin
            if (w_rst_new)
                r_rst_p <= 1'b1;
            if (w_done && (r_sel == SEL_FIN)) begin
                r_fin_p    <= 1'b0;
                r_fin_done <= 1'b1;
            end else if (w_fin_new) begin
                r_fin_p <= 1'b1;
            end
        end
    end

    // Keep-alive handshake: ka_send stays high one cycle past completion,
    // so block re-selection until the requester lets go.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ka_done <= 1'b0;
            r_ka_sent <= 1'b0;
        end else begin
            r_ka_sent <= w_done && (r_sel == SEL_KA);
            if (w_closed)
                r_ka_done <= 1'b0;
            else if (w_done && (r_sel == SEL_KA))
                r_ka_done <= 1'b1;
            else if (!i_ka_send)
                r_ka_done <= 1'b0;
        end
    end

    assign o_ka_sent = r_ka_sent;
    assign o_meta    = r_meta;

endmodule
`default_nettype wire

// File: tb/tb_qnigma_tcp_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_qnigma_tcp_tx_arb
// Description : Scoreboard bench for qnigma_tcp_tx_arb. Directed stimulus
//               pushes hand-computed descriptors; a monitor pops them on
//               each descriptor handshake and models the tx path.
// Revision    : 1.0  initial release
// ============================================================================
module tb_qnigma_tcp_tx_arb;
    import qnigma_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_ms;
    tcb_t         tcb;
    logic         ka_send;
    logic         ka_sent;
    logic         ack_req;
    logic         dat_req;
    logic [15:0]  dat_len;
    logic         dat_ack;
    logic         fin_req;
    logic         rst_req;
    logic         meta_val;
    logic         meta_rdy;
    tcp_tx_meta_t meta;
    logic         tx_done = 1'b0;

    always #5 clk = ~clk;

    qnigma_tcp_tx_arb dut (
        .clk        (clk),
        .rst        (rst),
        .i_tick_ms  (tick_ms),
        .i_tcb      (tcb),
        .i_ka_send  (ka_send),
        .o_ka_sent  (ka_sent),
        .i_ack_req  (ack_req),
        .i_dat_req  (dat_req),
        .i_dat_len  (dat_len),
        .o_dat_ack  (dat_ack),
        .i_fin_req  (fin_req),
        .i_rst_req  (rst_req),
        .o_meta_val (meta_val),
        .i_meta_rdy (meta_rdy),
        .o_meta     (meta),
        .i_tx_done  (tx_done)
    );

    typedef struct {
        tcp_tx_meta_t m;
        bit           ka;
        bit           dat;
    } exp_t;

    exp_t sb[$];
    int   n_chk   = 0;
    int   n_err   = 0;
    int   done_cd = 0;
    int   tx_lat  = 1;
    bit   pend_ka = 1'b0;
    bit   cur_ka  = 1'b0;
    int   ka_cnt  = 0;
    int   dack_cnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic tcp_tx_meta_t mk(input logic [7:0] f, input logic [31:0] s,
                                        input logic [31:0] a, input logic [15:0] w,
                                        input logic [15:0] l);
        tcp_tx_meta_t t;
        t.flags = f; t.seq = s; t.ack = a; t.wnd = w; t.len = l;
        return t;
    endfunction

    task automatic push(input tcp_tx_meta_t m, input bit ka, input bit dat);
        exp_t e;
        e.m = m; e.ka = ka; e.dat = dat;
        sb.push_back(e);
    endtask

    // Monitor + tx path model
    initial begin : mon
        exp_t e;
        bit   exp_d;
        forever begin
            @(negedge clk);
            if (pend_ka || ka_sent)
                chk("ka_sent", 128'(ka_sent), 128'(pend_ka));
            pend_ka = 1'b0;
            ka_cnt += int'(ka_sent);
            exp_d = 1'b0;
            if (meta_val && meta_rdy && sb.size() != 0)
                exp_d = sb[0].dat;
            if (dat_ack || exp_d)
                chk("dat_ack", 128'(dat_ack), 128'(exp_d));
            dack_cnt += int'(dat_ack);
            tx_done = 1'b0;
            if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0) begin
                    tx_done = 1'b1;
                    pend_ka = cur_ka;
                end
            end
            if (meta_val && meta_rdy) begin
                if (done_cd != 0 || tx_done)
                    chk("one_in_flight", 128'(1), 128'(0));
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_frame: got %h expected none", meta);
                end else begin
                    e = sb.pop_front();
                    chk("meta", {24'd0, meta}, {24'd0, e.m});
                    cur_ka = e.ka;
                end
                done_cd = tx_lat;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack_req = 1'b1; @(negedge clk); ack_req = 1'b0;
    endtask

    task automatic pulse_fin();
        fin_req = 1'b1; @(negedge clk); fin_req = 1'b0;
    endtask

    task automatic tick();
        tick_ms = 1'b1; @(negedge clk); tick_ms = 1'b0; @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while ((sb.size() != 0 || done_cd != 0 || tx_done || meta_val) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk(nm, 128'(0), 128'(1));
        cyc(3);
    endtask

    initial begin : stim
        int k;
        rst = 1'b1; tick_ms = 1'b0; ka_send = 1'b0; ack_req = 1'b0;
        dat_req = 1'b0; dat_len = 16'd0; fin_req = 1'b0; rst_req = 1'b0;
        meta_rdy = 1'b1;
        tcb.status = tcp_established; tcb.loc_seq = 32'd0;
        tcb.loc_ack = 32'd5; tcb.loc_wnd = 16'h1000;
        cyc(3);
        chk("rst_meta_val", 128'(meta_val), 128'(0));
        chk("rst_ka_sent",  128'(ka_sent),  128'(0));
        chk("rst_dat_ack",  128'(dat_ack),  128'(0));
        chk("rst_meta",     {24'd0, meta},  128'(0));
        rst = 1'b0;
        cyc(2);

        // Keep-alive: seq wraps to FFFF_FFFF, two-cycle latency
        push(mk(c_TCP_ACK, 32'hFFFF_FFFF, 32'd5, 16'h1000, 16'd0), 1'b1, 1'b0);
        ka_send = 1'b1;
        @(negedge clk); chk("ka_lat1", 128'(meta_val), 128'(0));
        @(negedge clk); chk("ka_lat2", 128'(meta_val), 128'(1));
        k = 0;
        while (!ka_sent && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) chk("ka_sent_timeout", 128'(0), 128'(1));
        ka_send = 1'b0;
        cyc(20);
        chk("ka_once",  128'(ka_cnt),    128'(1));
        chk("ka_sb",    128'(sb.size()), 128'(0));

        // Single ack_req: pure ACK only after 4 ticks
        tcb.loc_seq = 32'h1000_0000; tcb.loc_ack = 32'h2000_0000; tcb.loc_wnd = 16'h0800;
        push(mk(c_TCP_ACK, 32'h1000_0000, 32'h2000_0000, 16'h0800, 16'd0), 1'b0, 1'b0);
        pulse_ack();
        repeat (3) tick();
        cyc(5);
        chk("ack_hold_val", 128'(meta_val),  128'(0));
        chk("ack_hold_sb",  128'(sb.size()), 128'(1));
        tick();
        wait_idle("ack_dly_timeout");

        // Two ack_req within one tick: immediate pure ACK
        push(mk(c_TCP_ACK, 32'h1000_0000, 32'h2000_0000, 16'h0800, 16'd0), 1'b0, 1'b0);
        pulse_ack();
        pulse_ack();
        k = 0;
        while (!meta_val && k < 4) begin @(negedge clk); k++; end
        chk("ack_coalesce_fast", 128'(meta_val), 128'(1));
        wait_idle("ack_coal_timeout");

        // Data with ACK owed: one PSH|ACK frame, no separate pure ACK
        push(mk(c_TCP_PSH | c_TCP_ACK, 32'h1000_0000, 32'h2000_0000, 16'h0800, 16'd100), 1'b0, 1'b1);
        ack_req = 1'b1; dat_req = 1'b1; dat_len = 16'd100;
        @(negedge clk); ack_req = 1'b0;
        k = 0;
        while (!dat_ack && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) chk("dat_ack_timeout", 128'(0), 128'(1));
        dat_req = 1'b0;
        wait_idle("dat_timeout");
        repeat (6) tick();
        cyc(3);
        chk("dat_ack_cnt", 128'(dack_cnt), 128'(1));
        chk("dat_no_ack",  128'(meta_val), 128'(0));

        // Simultaneous RST/FIN/DATA/KA: RST alone, then silence
        tcb.loc_seq = 32'h3000_0000; tcb.loc_ack = 32'h4000_0000; tcb.loc_wnd = 16'h0400;
        push(mk(c_TCP_RST, 32'h3000_0000, 32'd0, 16'h0400, 16'd0), 1'b0, 1'b0);
        rst_req = 1'b1; fin_req = 1'b1; dat_req = 1'b1; dat_len = 16'd20; ka_send = 1'b1;
        @(negedge clk); rst_req = 1'b0; fin_req = 1'b0;
        wait_idle("rst_timeout");
        pulse_ack();
        repeat (5) tick();
        pulse_fin();
        cyc(10);
        chk("rst_quiet",    128'(meta_val), 128'(0));
        chk("rst_no_dat",   128'(dack_cnt), 128'(1));
        chk("rst_no_ka",    128'(ka_cnt),   128'(1));
        dat_req = 1'b0; ka_send = 1'b0;
        tcb.status = tcp_closed;
        cyc(3);
        tcb.status = tcp_established;
        cyc(3);

        // Back-pressure: descriptor held stable, withdrawn on close
        meta_rdy = 1'b0;
        pulse_fin();
        k = 0;
        while (!meta_val && k < 10) begin @(negedge clk); k++; end
        chk("fin_meta", {24'd0, meta},
            {24'd0, mk(c_TCP_FIN | c_TCP_ACK, 32'h3000_0000, 32'h4000_0000, 16'h0400, 16'd0)});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_val",  128'(meta_val), 128'(1));
            chk("hold_meta", {24'd0, meta},
                {24'd0, mk(c_TCP_FIN | c_TCP_ACK, 32'h3000_0000, 32'h4000_0000, 16'h0400, 16'd0)});
        end
        tcb.status = tcp_closed;
        cyc(2);
        chk("flush_val", 128'(meta_val), 128'(0));
        meta_rdy = 1'b1;
        cyc(2);
        tcb.status = tcp_established;
        cyc(10);
        chk("flush_quiet", 128'(meta_val), 128'(0));

        // Close during WAIT: frame completes, all pending state dropped
        tx_lat = 8;
        push(mk(c_TCP_FIN | c_TCP_ACK, 32'h3000_0000, 32'h4000_0000, 16'h0400, 16'd0), 1'b0, 1'b0);
        pulse_fin();
        k = 0;
        while (sb.size() != 0 && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) chk("wait_fin_timeout", 128'(0), 128'(1));
        pulse_ack();
        pulse_ack();
        tcb.status = tcp_closed;
        cyc(12);
        chk("closed_wait_val", 128'(meta_val), 128'(0));
        tcb.status = tcp_established;
        tx_lat = 1;
        cyc(20);
        chk("closed_quiet", 128'(meta_val), 128'(0));
        push(mk(c_TCP_FIN | c_TCP_ACK, 32'h3000_0000, 32'h4000_0000, 16'h0400, 16'd0), 1'b0, 1'b0);
        pulse_fin();
        wait_idle("refin_timeout");

        cyc(5);
        chk("sb_final", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
